jtframe_lfbuf_wrline: RTL and testbench

Write-side line stage for the DECA line-frame buffer. It collects one video line from the game core (`ln_addr`/`ln_data`/`ln_we`/`ln_done`) into a ping-pong line RAM. On each `ln_done` it swaps banks and flushes the finished line to DDR3 as fixed-length Avalon-style burst writes. It sits between the game core's line interface and the DDR3 port of `jtframe_lfbuf_ddr_deca`, which handles readout to video.

---
 rtl/jtframe_lfbuf_pkg.sv | 29 ++
 rtl/jtframe_dual_ram.sv | 28 ++
 rtl/jtframe_lfbuf_wrline.sv | 162 ++++++++++++++++
 tb/tb_jtframe_lfbuf_wrline.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_lfbuf_pkg.sv
// Shared definitions for the DECA line-frame buffer write-line stage.
//   LINE_WORDS : 64-bit words per video line (512 pixels / 4 lanes)
//   LANES      : 16-bit pixel lanes packed into one DDR word
//   PXLW       : pixel width in bits
//   state_t    : flush FSM states
//   lfbuf_offset() : DDR word offset of a word inside a frame/line
package jtframe_lfbuf_pkg;

   localparam int LINE_WORDS = 128;
   localparam int LANES      = 4;
   localparam int PXLW       = 16;
   localparam int WORDW      = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      BURST = 2'd2
   } state_t;

   // {frame, line, word}: one frame holds 256 lines of 128 DDR words
   function automatic logic [15:0] lfbuf_offset(
      input logic             frame,
      input logic [7:0]       line,
      input logic [WORDW-1:0] word
   );
      return {frame, line, word};
   endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM, one clock.
//   Port A : write only (clk_i, we_a_i, addr_a_i, data_a_i)
//   Port B : registered read with optional write (we_b_i, addr_b_i,
//            data_b_i, q_b_o). Read-first: q_b_o returns the contents
//            before a same-cycle port B write.
module jtframe_dual_ram #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk_i,
   input  logic          we_a_i,
   input  logic [AW-1:0] addr_a_i,
   input  logic [DW-1:0] data_a_i,
   input  logic          we_b_i,
   input  logic [AW-1:0] addr_b_i,
   input  logic [DW-1:0] data_b_i,
   output logic [DW-1:0] q_b_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk_i) begin
      if (we_a_i) mem_q[addr_a_i] <= data_a_i;
      q_b_o <= mem_q[addr_b_i];
      if (we_b_i) mem_q[addr_b_i] <= data_b_i;
   end

endmodule

// File: rtl/jtframe_lfbuf_wrline.sv
// Write-side line stage of the DECA line-frame buffer.
// Collects one line from the game core into a ping-pong line RAM and, on
// each ln_done, swaps banks and flushes the finished line to DDR3 as
// fixed-length burst writes.
//
// Parameters: FBASE (DDR word base of the frame area), BLEN (beats/burst).
// Ports:
//   clk_i, rst_i (sync, active-high)
//   ln_addr_i/ln_data_i/ln_we_i : game pixel writes
//   ln_done_i, ln_v_i, frame_i  : end of line, line number, target frame
//   ddram_busy_i                : DDR back-pressure
//   ddram_addr_o/din_o/be_o/we_o/burstcnt_o : DDR burst write port
//   busy_o : flush in progress;  ovf_o : dropped ln_done pulse
// Build option: define JTFRAME_LFBUF_CLR_EN to zero each word of the
// flushed bank as it is read, so undrawn pixels come back as colour 0.
//
// state | meaning
// IDLE  | no flush pending, waiting for ln_done
// LOAD  | RAM read of word 0 issued, data valid next cycle
// BURST | ddram_we_o high, one word per accepted beat
module jtframe_lfbuf_wrline
   import jtframe_lfbuf_pkg::*;
#(
   parameter logic [28:0] FBASE = 29'h0,
   parameter int          BLEN  = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [8:0]  ln_addr_i,
   input  logic [15:0] ln_data_i,
   input  logic        ln_we_i,
   input  logic        ln_done_i,
   input  logic [7:0]  ln_v_i,
   input  logic        frame_i,
   input  logic        ddram_busy_i,
   output logic [28:0] ddram_addr_o,
   output logic [63:0] ddram_din_o,
   output logic [7:0]  ddram_be_o,
   output logic        ddram_we_o,
   output logic [7:0]  ddram_burstcnt_o,
   output logic        busy_o,
   output logic        ovf_o
);

   localparam logic [WORDW-1:0] BMASK = WORDW'(BLEN - 1);
   localparam logic [WORDW-1:0] LAST  = WORDW'(LINE_WORDS - 1);

   state_t           state_q, state_d;
   logic             wbank_q;
   logic [7:0]       line_q;
   logic             frame_q;
   logic [WORDW-1:0] word_q;
   logic [28:0]      addr_q;
   logic             fetch_vld_q;
   logic [63:0]      hold_q;
   logic             ovf_q;

   logic             beat_ok, last_word, done_ok;
   logic             fetch, clr_we;
   logic [WORDW-1:0] rd_word, next_word;
   logic [PXLW-1:0]  lane_q [LANES];
   logic [63:0]      ram_word, din;

   assign beat_ok   = (state_q == BURST) & ~ddram_busy_i;
   assign last_word = (word_q == LAST);
   assign next_word = word_q + 7'd1;
   assign done_ok   = ln_done_i & ((state_q == IDLE) | (beat_ok & last_word));

   always_comb begin
      state_d = state_q;
      fetch   = 1'b0;
      rd_word = word_q;
      case (state_q)
         IDLE: begin
            if (done_ok) state_d = LOAD;
         end
         LOAD: begin
            fetch   = 1'b1;
            state_d = BURST;
         end
         BURST: begin
            if (beat_ok) begin
               if (last_word) begin
                  state_d = done_ok ? LOAD : IDLE;
               end else begin
                  // prefetch the next word so it is ready for the next beat
                  fetch   = 1'b1;
                  rd_word = next_word;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef JTFRAME_LFBUF_CLR_EN
   // read-first RAM: the fetch sees the old word, which reads as 0 after
   assign clr_we = fetch & ~rst_i;
`else
   assign clr_we = 1'b0;
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      jtframe_dual_ram #(
         .AW(8),
         .DW(PXLW)
      ) u_ram (
         .clk_i    (clk_i),
         .we_a_i   (ln_we_i & (ln_addr_i[1:0] == 2'(l))),
         .addr_a_i ({wbank_q, ln_addr_i[8:2]}),
         .data_a_i (ln_data_i),
         .we_b_i   (clr_we),
         .addr_b_i ({~wbank_q, rd_word}),
         .data_b_i ('0),
         .q_b_o    (lane_q[l])
      );
   end

   assign ram_word = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
   // RAM output is only fresh the cycle after a fetch; afterwards the
   // held copy keeps the beat stable through DDR back-pressure
   assign din      = fetch_vld_q ? ram_word : hold_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         wbank_q     <= 1'b0;
         line_q      <= '0;
         frame_q     <= 1'b0;
         word_q      <= '0;
         addr_q      <= '0;
         fetch_vld_q <= 1'b0;
         hold_q      <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_vld_q <= fetch;
         hold_q      <= din;
         ovf_q       <= ln_done_i & ~done_ok;
         if (done_ok) begin
            wbank_q <= ~wbank_q;
            line_q  <= ln_v_i;
            frame_q <= frame_i;
            word_q  <= '0;
            addr_q  <= FBASE + 29'(lfbuf_offset(frame_i, ln_v_i, '0));
         end else if (beat_ok & ~last_word) begin
            word_q <= next_word;
            if ((next_word & BMASK) == '0)
               addr_q <= FBASE + 29'(lfbuf_offset(frame_q, line_q, next_word));
         end
      end
   end

   assign ddram_addr_o     = addr_q;
   assign ddram_din_o      = din;
   assign ddram_be_o       = 8'hFF;
   assign ddram_we_o       = (state_q == BURST);
   assign ddram_burstcnt_o = 8'(BLEN);
   assign busy_o           = (state_q != IDLE);
   assign ovf_o            = ovf_q;

endmodule

// File: tb/tb_jtframe_lfbuf_wrline.sv
// Self-checking bench for jtframe_lfbuf_wrline: a bank model predicts the
// beats of every accepted line into a queue, a negedge monitor pops and
// compares each accepted beat (and the held beat during DDR busy).
module tb_jtframe_lfbuf_wrline;

   localparam logic [28:0] FBASE = 29'h0010_0000;
   localparam int          BLEN  = 32;

   typedef struct packed {
      logic [28:0] addr;
      logic [63:0] din;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [8:0]  ln_addr = '0;
   logic [15:0] ln_data = '0;
   logic        ln_we = 1'b0;
   logic        ln_done = 1'b0;
   logic [7:0]  ln_v = '0;
   logic        frame = 1'b0;
   logic        ddram_busy = 1'b0;
   logic [28:0] ddram_addr;
   logic [63:0] ddram_din;
   logic [7:0]  ddram_be;
   logic        ddram_we;
   logic [7:0]  ddram_burstcnt;
   logic        busy;
   logic        ovf;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ovf_cnt = 0;
   int          we_rise = -1;
   logic        we_prev = 1'b0;
   beat_t       exp_q[$];
   logic [15:0] bank_m [2][512];
   logic        wbank_m = 1'b0;

   jtframe_lfbuf_wrline #(
      .FBASE(FBASE),
      .BLEN (BLEN)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .ln_addr_i       (ln_addr),
      .ln_data_i       (ln_data),
      .ln_we_i         (ln_we),
      .ln_done_i       (ln_done),
      .ln_v_i          (ln_v),
      .frame_i         (frame),
      .ddram_busy_i    (ddram_busy),
      .ddram_addr_o    (ddram_addr),
      .ddram_din_o     (ddram_din),
      .ddram_be_o      (ddram_be),
      .ddram_we_o      (ddram_we),
      .ddram_burstcnt_o(ddram_burstcnt),
      .busy_o          (busy),
      .ovf_o           (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual %h required %h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   function automatic logic [15:0] pat(input int k, input int p);
      return 16'(p * (k + 1)) ^ 16'(k * 'h1111);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_px(input int p, input logic [15:0] v);
      ln_addr = 9'(p);
      ln_data = v;
      ln_we   = 1'b1;
      bank_m[wbank_m][p] = v;
      step();
      ln_we   = 1'b0;
   endtask

   task automatic wr_line(input int k, input int first, input int last);
      for (int p = first; p <= last; p++) wr_px(p, pat(k, p));
   endtask

   task automatic push_line(input logic b, input logic fr, input logic [7:0] ln);
      beat_t e;
      logic [6:0] w7;
      for (int w = 0; w < 128; w++) begin
         w7     = 7'(w);
         e.addr = FBASE + 29'({fr, ln, w7 & 7'h60});
         e.din  = {bank_m[b][4*w+3], bank_m[b][4*w+2], bank_m[b][4*w+1], bank_m[b][4*w]};
         exp_q.push_back(e);
      end
   endtask

   // drives a one-cycle ln_done; n is the cycle in which it is high
   task automatic pulse_done(input logic [7:0] ln, input logic fr, input bit accept, output int n);
      ln_v    = ln;
      frame   = fr;
      ln_done = 1'b1;
      n       = cyc;
      if (accept) begin
         wbank_m = ~wbank_m;
         push_line(~wbank_m, fr, ln);
`ifdef JTFRAME_LFBUF_CLR_EN
         for (int p = 0; p < 512; p++) bank_m[~wbank_m][p] = 16'h0;
`endif
      end
      step();
      ln_done = 1'b0;
   endtask

   task automatic wait_idle(output int fall);
      int n = 0;
      @(negedge clk);
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      fall = cyc;
      if (busy) chk("flush_timeout", 64'(busy), 64'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && ddram_we) begin
         if (exp_q.size() == 0) begin
            chk("beat_unexpected", 64'(ddram_addr), 64'h1FFF_FFFF);
         end else begin
            chk("beat_addr", 64'(ddram_addr), 64'(exp_q[0].addr));
            chk("beat_din", ddram_din, exp_q[0].din);
            if (!ddram_busy) void'(exp_q.pop_front());
         end
      end
      if (ovf) ovf_cnt++;
      if (ddram_we && !we_prev) we_rise = cyc;
      we_prev = ddram_we;
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n2, fall;

      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("rst_we", 64'(ddram_we), 64'd0);
      chk("rst_addr", 64'(ddram_addr), 64'd0);
      chk("rst_din", ddram_din, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_be", 64'(ddram_be), 64'hFF);
      chk("rst_burstcnt", 64'(ddram_burstcnt), 64'd32);
      step();
      rst = 1'b0;
      step();

      // line 5 frame 0, pixel p = p, no back-pressure
      wr_line(0, 0, 511);
      pulse_done(8'd5, 1'b0, 1'b1, n);
      @(negedge clk);
      chk("t1_busy_n1", 64'(busy), 64'd1);
      chk("t1_we_n1", 64'(ddram_we), 64'd0);
      chk("t1_first_addr", 64'(ddram_addr), 64'(FBASE + 29'h280));
      wait_idle(fall);
      chk("t1_first_we_cycle", 64'(we_rise - n), 64'd2);
      chk("t1_busy_fall", 64'(fall - n), 64'd130);

      // same line, DDR busy for 3 cycles on beat 10
      wr_line(1, 0, 511);
      pulse_done(8'd5, 1'b0, 1'b1, n);
      while (cyc < n + 12) step();
      ddram_busy = 1'b1;
      step();
      step();
      step();
      ddram_busy = 1'b0;
      wait_idle(fall);
      chk("t2_busy_fall", 64'(fall - n), 64'd133);

      // ln_done at beat 50 is dropped; game keeps writing its own bank
      wr_line(2, 0, 511);
      pulse_done(8'd7, 1'b1, 1'b1, n);
      while (cyc < n + 52) step();
      @(negedge clk);
      chk("t3_ovf_before", 64'(ovf), 64'd0);
      pulse_done(8'd9, 1'b0, 1'b0, n2);
      @(negedge clk);
      chk("t3_ovf_pulse", 64'(ovf), 64'd1);
      wr_line(3, 0, 0);
      @(negedge clk);
      chk("t3_ovf_one_cycle", 64'(ovf), 64'd0);
      wr_line(3, 1, 63);
      wait_idle(fall);
      chk("t3_busy_fall", 64'(fall - n), 64'd130);

      // finish that line, flush it, and chain a partially drawn line on
      // the exact cycle of the last accepted beat
      wr_line(3, 64, 511);
      pulse_done(8'd20, 1'b0, 1'b1, n);
      wr_line(4, 0, 99);
      while (cyc < n + 129) step();
      pulse_done(8'd21, 1'b1, 1'b1, n2);
      @(negedge clk);
      chk("t4_gap_we", 64'(ddram_we), 64'd0);
      chk("t4_gap_busy", 64'(busy), 64'd1);
      chk("t4_no_ovf", 64'(ovf), 64'd0);
      step();
      @(negedge clk);
      chk("t4_chain_we", 64'(ddram_we), 64'd1);

      // reset while beat 70 of the chained line is presented
      while (cyc < n2 + 72) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_rst_we", 64'(ddram_we), 64'd0);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk("t5_rst_remaining", 64'(exp_q.size()), 64'd58);
      exp_q.delete();
      wbank_m = 1'b0;

      // full line after reset lands in bank 0
      wr_line(6, 0, 511);
      pulse_done(8'd100, 1'b0, 1'b1, n);
      wait_idle(fall);
      chk("t6_busy_fall", 64'(fall - n), 64'd130);

      // partial line in bank 1: the rest shows the older line (or zeros)
      wr_line(7, 0, 127);
      pulse_done(8'd255, 1'b1, 1'b1, n);
      wait_idle(fall);
      chk("t7_busy_fall", 64'(fall - n), 64'd130);

      step();
      chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("end_ovf_count", 64'(ovf_cnt), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
